fsm_serial_tx: RTL
==================

// Module: fsm_serial_tx
// PURPOSE
//  Serial-line transmitter: the upstream stage of the serial receiver FSM. Accepts bytes over a
//  valid/ready handshake and serialises each one onto one wire: start bit (0), 8 data bits LSB
//  first, optional parity bit, then 1-2 stop bits (1). The line idles at 1. A one-entry holding
//  register allows back-to-back frames with no idle gap between them.
// PARAMETERS
//  CLKS_PER_BIT  1  clock cycles per serial bit (>=1); 1 matches the receiver's 1-bit-per-clock rate
//  PARITY_EN     0  1 = insert a parity bit after D7
//  PARITY_ODD    0  0 = even parity, 1 = odd parity (ignored when PARITY_EN=0)
//  STOP_BITS     1  number of stop bits, 1 or 2
// PORTS
//  clk         in   1  single clock, rising edge
//  reset_n     in   1  asynchronous, active-low reset
//  in_data     in   8  byte to send
//  in_valid    in   1  in_data is valid
//  in_ready    out  1  holding register is empty; transfer occurs on in_valid && in_ready
//  tx          out  1  serial line, registered, idles at 1
//  busy        out  1  a frame is being shifted (state != IDLE)
//  frame_done  out  1  one-cycle pulse on the last clock of the final stop bit
// BEHAVIOUR
//  - Reset (async, reset_n=0): tx=1, in_ready=1, busy=0, frame_done=0; state=IDLE;
//    hold register empty; all counters 0. Asserting reset mid-frame forces tx=1 at once and
//    drops both the frame in flight and the held byte.
//  - Handshake: when in_valid && in_ready at edge N, the byte is written to hold and in_ready=0
//    from N. in_ready returns to 1 on the edge after the FSM loads the shifter from hold.
//    in_data is don't-care when no transfer occurs.
//  - FSM states: IDLE, START, DATA, PARITY, STOP.
//    IDLE:   tx=1. If hold is valid, load the shifter, clear hold and enter START on the next edge.
//    START:  tx=0 for CLKS_PER_BIT cycles -> DATA.
//    DATA:   tx=shift[0]; shift right every CLKS_PER_BIT cycles; bit index 0..7;
//            after bit 7 go to PARITY if PARITY_EN, else STOP.
//    PARITY: tx = ^byte ^ PARITY_ODD for CLKS_PER_BIT cycles -> STOP.
//    STOP:   tx=1 for STOP_BITS*CLKS_PER_BIT cycles. On the last cycle, frame_done=1. If hold is
//            valid, load the shifter and go directly to START (no idle bit); otherwise go to IDLE.
//  - Latency: byte accepted at edge N while IDLE with hold empty -> FSM loads at N+1 ->
//    the start bit is on tx from edge N+2.
//  - Frame length: (1 + 8 + PARITY_EN + STOP_BITS) * CLKS_PER_BIT cycles.
//  - Bit-period counter: width $clog2(CLKS_PER_BIT)+1; it wraps to 0 at CLKS_PER_BIT-1;
//    bit transitions occur only on wrap.
//  - Simultaneous load and new in_valid: in_ready is still 0 in the load cycle, so the new byte
//    is not taken. It is accepted one cycle later, well before the next STOP, so full throughput
//    is preserved.
//  - tx and frame_done are registered outputs; there is no combinational path from in_* to tx.
// STRUCTURE
//  - Shared package fsm_serial_pkg: typedef enum logic [2:0] tx_state_t
//    {IDLE, START, DATA, PARITY, STOP}; localparams START_BIT=1'b0, STOP_BIT=1'b1, DATA_BITS=8.
//  - Sub-module serial_bit_timer: CLKS_PER_BIT prescaler producing a bit_tick strobe, with a sync
//    restart input used on load. The FSM, shifter and hold register stay in fsm_serial_tx.
// TESTING
//  - Reset: reset_n=0 mid-frame (CLKS_PER_BIT=4) -> tx=1, busy=0, in_ready=1 at once, without
//    waiting for a clock edge.
//  - Single byte 0xA5, CLKS_PER_BIT=1, no parity -> tx from N+2 = 0,1,0,1,0,0,1,0,1,1, then idle at 1;
//    frame_done on the stop cycle only.
//  - Parity: PARITY_EN=1, 0xA5, even -> parity bit 0; odd -> parity bit 1; 0x01 even -> parity bit 1.
//  - Back-to-back: 0x00 then 0xFF offered on consecutive accepts -> 20 contiguous bits,
//    stop of frame 1 immediately followed by start of frame 2; 2 frame_done pulses 10 cycles apart.
//  - Backpressure: in_valid held high with 4 bytes, CLKS_PER_BIT=3, STOP_BITS=2 -> each in_ready
//    pulse accepts exactly one byte, no byte is lost or duplicated, frame period is 33 cycles.
//  - Loopback: tx drives the team's serial receiver FSM, 256 random bytes, CLKS_PER_BIT=1,
//    no parity -> receiver done asserts once per frame and the captured bytes match the sent order.

Source files
------------

// File: rtl/fsm_serial_pkg.sv
// Shared types and constants for the serial line transmitter and its receiver partner.
package fsm_serial_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam int   DATA_BITS = 8;

  function automatic logic frame_parity(input logic [DATA_BITS-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/fsm_serial_tx_bit_timer.sv
// Bit-period prescaler: bit_tick_o marks the last clock of each serial bit.
module serial_bit_timer
  import fsm_serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic restart_i,
  output logic bit_tick_o
);

  localparam int               CNT_W    = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Restart parks the count at zero so a freshly loaded frame gets a full first bit.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart_i || (cnt_q == CNT_LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_tick_o = (cnt_q == CNT_LAST);

endmodule

// File: rtl/fsm_serial_tx.sv
// Serial line transmitter: start bit, 8 data bits LSB first, optional parity, 1-2 stop bits.
// A one-entry holding register lets the next frame start straight after the current stop bit.
module fsm_serial_tx
  import fsm_serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  tx_state_t            state_q;
  logic [DATA_BITS-1:0] hold_q;
  logic                 hold_vld_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_q;
  logic [2:0]           bit_idx_q;
  logic                 stop_idx_q;
  logic                 tx_q;
  logic                 done_q;

  logic bit_tick;
  logic accept;
  logic last_stop;
  logic load;
  logic restart;

  assign accept    = in_valid && !hold_vld_q;
  assign last_stop = (stop_idx_q == 1'(STOP_BITS - 1));
  // The shifter is refilled either from idle or on the final clock of the last stop bit.
  assign load      = hold_vld_q &&
                     ((state_q == IDLE) || ((state_q == STOP) && bit_tick && last_stop));
  assign restart   = load || (state_q == IDLE);

  serial_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk_i     (clk),
    .rst_ni    (reset_n),
    .restart_i (restart),
    .bit_tick_o(bit_tick)
  );

  always_ff @(posedge clk) begin
    if (accept) begin
      hold_q <= in_data;
    end
    if (load) begin
      shift_q <= hold_q;
      par_q   <= frame_parity(hold_q, PARITY_ODD != 0);
    end else if ((state_q == DATA) && bit_tick) begin
      shift_q <= shift_q >> 1;
    end
  end

  // tx and frame_done are registered from the current state, so the line trails the state by one clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      hold_vld_q <= 1'b0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      tx_q       <= STOP_BIT;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        hold_vld_q <= 1'b1;
      end else if (load) begin
        hold_vld_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          tx_q <= STOP_BIT;
        end
        START: begin
          tx_q <= START_BIT;
          if (bit_tick) begin
            state_q <= DATA;
          end
        end
        DATA: begin
          tx_q <= shift_q[0];
          if (bit_tick) begin
            if (bit_idx_q == 3'(DATA_BITS - 1)) begin
              bit_idx_q  <= '0;
              stop_idx_q <= 1'b0;
              state_q    <= (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end
        end
        PARITY: begin
          tx_q <= par_q;
          if (bit_tick) begin
            state_q <= STOP;
          end
        end
        STOP: begin
          tx_q <= STOP_BIT;
          if (bit_tick) begin
            if (last_stop) begin
              done_q     <= 1'b1;
              stop_idx_q <= 1'b0;
              state_q    <= IDLE;
            end else begin
              stop_idx_q <= stop_idx_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= STOP_BIT;
        end
      endcase
      if (load) begin
        bit_idx_q  <= '0;
        stop_idx_q <= 1'b0;
        state_q    <= START;
      end
    end
  end

  assign in_ready   = !hold_vld_q;
  assign tx         = tx_q;
  assign busy       = (state_q != IDLE);
  assign frame_done = done_q;

endmodule
